// File: rtl/lc3_controller.sv
// LC-3 multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback/PC-update control.
// All outputs are registered Moore functions of the state; memory waits are bounded by MEM_TIMEOUT.
module lc3_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] Instr_dout,
  input  logic [2:0]  NZP,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        enable_updatePC,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        mem_timeout
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM_IND,
    S_MEM_RD,
    S_MEM_WR,
    S_WRITEBACK,
    S_UPDATE_PC
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;
  logic        mto_q, mto_d;
  logic        br_d;
  logic [1:0]  mem_state_d;
  logic        fetch_q, decode_q, execute_q, writeback_q, updpc_q, br_q;
  logic [1:0]  mem_state_q;

  logic [3:0]  opcode;
  logic        mem_wait;
  logic        mem_expired;
  state_t      mem_next;

  assign opcode      = ir_q[15:12];
  assign mem_wait    = (state_q == S_MEM_IND) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign mem_expired = (wait_q == WAIT_LAST);

  // LDI and STI share the indirect read; ir[12] separates the load from the store.
  always_comb begin
    mem_next = S_UPDATE_PC;
    case (state_q)
      S_MEM_IND: mem_next = ir_q[12] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  mem_next = S_WRITEBACK;
      default:   mem_next = S_UPDATE_PC;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    mto_d   = mto_q;
    br_d    = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (complete_instr) begin
          ir_d    = Instr_dout;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        wait_d = '0;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_LEA: state_d = S_WRITEBACK;
          OP_LD, OP_LDR:                  state_d = S_MEM_RD;
          OP_ST, OP_STR:                  state_d = S_MEM_WR;
          OP_LDI, OP_STI:                 state_d = S_MEM_IND;
          OP_BR: begin
            state_d = S_UPDATE_PC;
            br_d    = |(ir_q[11:9] & NZP);
          end
          OP_JMP: begin
            state_d = S_UPDATE_PC;
            br_d    = 1'b1;
          end
          default: state_d = S_UPDATE_PC;
        endcase
      end
      S_MEM_IND, S_MEM_RD, S_MEM_WR: begin
        if (complete_data || mem_expired) begin
          state_d = mem_next;
          wait_d  = '0;
          // A completion landing on the expiry edge is a normal completion.
          if (!complete_data) mto_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_FETCH;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_state_d = 2'd3;
    case (state_d)
      S_MEM_IND: mem_state_d = 2'd0;
      S_MEM_RD:  mem_state_d = 2'd1;
      S_MEM_WR:  mem_state_d = 2'd2;
      default:   mem_state_d = 2'd3;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ir_q        <= 16'h0000;
      wait_q      <= '0;
      mto_q       <= 1'b0;
      fetch_q     <= 1'b0;
      decode_q    <= 1'b0;
      execute_q   <= 1'b0;
      writeback_q <= 1'b0;
      updpc_q     <= 1'b0;
      br_q        <= 1'b0;
      mem_state_q <= 2'd3;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      wait_q      <= wait_d;
      mto_q       <= mto_d;
      fetch_q     <= (state_d == S_FETCH);
      decode_q    <= (state_d == S_DECODE);
      execute_q   <= (state_d == S_EXECUTE);
      writeback_q <= (state_d == S_WRITEBACK);
      updpc_q     <= (state_d == S_UPDATE_PC);
      br_q        <= (state_d == S_UPDATE_PC) && br_d;
      mem_state_q <= mem_state_d;
    end
  end

  assign enable_fetch     = fetch_q;
  assign enable_decode    = decode_q;
  assign enable_execute   = execute_q;
  assign enable_writeback = writeback_q;
  assign enable_updatePC  = updpc_q;
  assign br_taken         = br_q;
  assign mem_state        = mem_state_q;
  assign mem_timeout      = mto_q;

  logic unused_ok;
  assign unused_ok = mem_wait;

endmodule

// File: tb/tb_lc3_controller.sv
// Randomized self-checking bench for lc3_controller against a per-cycle stage-sequence model.
module tb_lc3_controller;
  localparam int T = 15;

  localparam int ST_F   = 0;
  localparam int ST_DEC = 1;
  localparam int ST_EXE = 2;
  localparam int ST_IND = 3;
  localparam int ST_RD  = 4;
  localparam int ST_WR  = 5;
  localparam int ST_WB  = 6;
  localparam int ST_UPD = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        complete_instr = 1'b0;
  logic        complete_data = 1'b0;
  logic [15:0] Instr_dout = 16'h0000;
  logic [2:0]  NZP = 3'b000;
  logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        mem_timeout;

  int n_checks = 0;
  int n_fail = 0;
  bit model_mto = 1'b0;

  lc3_controller #(.MEM_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .complete_instr(complete_instr), .complete_data(complete_data),
    .Instr_dout(Instr_dout), .NZP(NZP),
    .enable_fetch(enable_fetch), .enable_decode(enable_decode),
    .enable_execute(enable_execute), .enable_writeback(enable_writeback),
    .enable_updatePC(enable_updatePC), .br_taken(br_taken),
    .mem_state(mem_state), .mem_timeout(mem_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] obs_vec();
    return {enable_fetch, enable_decode, enable_execute, enable_writeback,
            enable_updatePC, br_taken, mem_state, mem_timeout};
  endfunction

  // Expected outputs per stage: {fetch,decode,execute,writeback,updpc,br,mem_state,timeout}
  function automatic logic [8:0] exp_vec(input int stg, input bit br, input bit mto);
    case (stg)
      ST_F:    return {5'b10000, 1'b0, 2'd3, mto};
      ST_DEC:  return {5'b01000, 1'b0, 2'd3, mto};
      ST_EXE:  return {5'b00100, 1'b0, 2'd3, mto};
      ST_IND:  return {5'b00000, 1'b0, 2'd0, mto};
      ST_RD:   return {5'b00000, 1'b0, 2'd1, mto};
      ST_WR:   return {5'b00000, 1'b0, 2'd2, mto};
      ST_WB:   return {5'b00010, 1'b0, 2'd3, mto};
      ST_UPD:  return {5'b00001, br,   2'd3, mto};
      default: return {5'b00000, 1'b0, 2'd3, 1'b0};
    endcase
  endfunction

  // Starts at a negedge with the DUT in FETCH; ends at the negedge of the next FETCH
  // (or, with abort_at >= 0, holding reset after an asynchronous abort at that cycle).
  task automatic run_instr(input logic [15:0] instr, input logic [2:0] nzp, input int fw,
                           input int d0, input int d1, input int abort_at, input string tag);
    int stg_q[$];
    bit cd_q[$];
    bit mto_q[$];
    int mems[$];
    logic [3:0] op;
    bit wb, br, cur;
    logic [8:0] ev, ov;
    op  = instr[15:12];
    cur = model_mto;
    wb  = 1'b0;
    case (op)
      4'b0001, 4'b0101, 4'b1001, 4'b1110: wb = 1'b1;
      4'b0010, 4'b0110: begin mems.push_back(ST_RD); wb = 1'b1; end
      4'b1010: begin mems.push_back(ST_IND); mems.push_back(ST_RD); wb = 1'b1; end
      4'b0011, 4'b0111: mems.push_back(ST_WR);
      4'b1011: begin mems.push_back(ST_IND); mems.push_back(ST_WR); end
      default: ;
    endcase
    if (op == 4'b0000) br = |(instr[11:9] & nzp);
    else br = (op == 4'b1100);
    NZP = nzp;

    for (int i = 0; i <= fw; i++) begin
      ev = exp_vec(ST_F, 1'b0, cur);
      ov = obs_vec();
      n_checks++;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL %s fetch wait %0d: got %b expected %b", tag, i, ov, ev);
      end
      complete_instr = (i == fw);
      Instr_dout     = (i == fw) ? instr : 16'($urandom);
      complete_data  = 1'($urandom);
      @(negedge clock);
    end

    stg_q.push_back(ST_DEC); cd_q.push_back(1'($urandom)); mto_q.push_back(cur);
    stg_q.push_back(ST_EXE); cd_q.push_back(1'($urandom)); mto_q.push_back(cur);
    for (int j = 0; j < mems.size(); j++) begin
      int d, len;
      d   = (j == 0) ? d0 : d1;
      len = (d + 1 < T) ? d + 1 : T;
      for (int k = 1; k <= len; k++) begin
        stg_q.push_back(mems[j]); cd_q.push_back(k == d + 1); mto_q.push_back(cur);
      end
      if (d + 1 > T) cur = 1'b1;
    end
    if (wb) begin
      stg_q.push_back(ST_WB); cd_q.push_back(1'($urandom)); mto_q.push_back(cur);
    end
    stg_q.push_back(ST_UPD); cd_q.push_back(1'($urandom)); mto_q.push_back(cur);

    for (int idx = 0; idx < stg_q.size(); idx++) begin
      ev = exp_vec(stg_q[idx], br, mto_q[idx]);
      ov = obs_vec();
      n_checks++;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL %s cycle %0d stage %0d: got %b expected %b", tag, idx, stg_q[idx], ov, ev);
      end
      if (idx == abort_at) begin
        #2 reset = 1'b0;
        #1;
        ev = exp_vec(-1, 1'b0, 1'b0);
        ov = obs_vec();
        n_checks++;
        if (ov !== ev) begin
          n_fail++;
          $display("FAIL %s async abort: got %b expected %b", tag, ov, ev);
        end
        @(negedge clock);
        model_mto = 1'b0;
        return;
      end
      complete_instr = 1'($urandom);
      Instr_dout     = 16'($urandom);
      complete_data  = cd_q[idx];
      @(negedge clock);
    end
    complete_instr = 1'b0;
    complete_data  = 1'b0;
    model_mto = cur;
  endtask

  task automatic release_reset(input string tag);
    bit seen;
    complete_instr = 1'b0;
    complete_data  = 1'b0;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clock);
      if (enable_fetch === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s fetch after release: got enable_fetch=%b expected 1 within 2 edges", tag, enable_fetch);
    end
    model_mto = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] ov;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    ov = obs_vec();
    n_checks++;
    if (ov !== exp_vec(-1, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", ov, exp_vec(-1, 1'b0, 1'b0));
    end
    release_reset("reset");
  endtask

  task automatic test_add();
    run_instr(16'h1042, 3'b000, 0, 0, 0, -1, "add");
    run_instr(16'h5000 | 16'($urandom_range(0, 4095)), 3'($urandom), 2, 0, 0, -1, "and");
  endtask

  task automatic test_ldi();
    run_instr(16'hA402, 3'b001, 0, 2, 2, -1, "ldi");
    run_instr(16'hB402, 3'b001, 1, 0, 3, -1, "sti");
  endtask

  task automatic test_branch();
    run_instr(16'h0405, 3'b010, 0, 0, 0, -1, "br_z_taken");
    run_instr(16'h0405, 3'b100, 0, 0, 0, -1, "br_z_not");
    run_instr(16'h01FF, 3'b111, 0, 0, 0, -1, "br_nzp000");
    run_instr(16'h0E00, 3'b001, 1, 0, 0, -1, "br_any");
    run_instr(16'hC1C0, 3'b000, 0, 0, 0, -1, "jmp");
  endtask

  task automatic test_nop();
    run_instr(16'hD123, 3'b111, 0, 0, 0, -1, "op1101");
    run_instr(16'h8000, 3'b010, 0, 0, 0, -1, "op1000");
    run_instr(16'hF025, 3'b001, 0, 0, 0, -1, "op1111");
    run_instr(16'h4ABC, 3'b100, 0, 0, 0, -1, "op0100");
  endtask

  task automatic test_timeout_boundary();
    run_instr(16'h3203, 3'b000, 0, T - 1, 0, -1, "st_edge");
    run_instr(16'h2203, 3'b000, 0, T - 2, 0, -1, "ld_edge_m1");
  endtask

  task automatic test_store_timeout();
    run_instr(16'h3203, 3'b000, 0, 40, 0, -1, "st_timeout");
    run_instr(16'h1042, 3'b000, 0, 0, 0, -1, "add_after_to");
    run_instr(16'h6203, 3'b000, 0, 3, 0, -1, "ldr_after_to");
  endtask

  task automatic test_back_to_back();
    run_instr(16'h7203, 3'b000, 0, 0, 0, -1, "b2b_str");
    run_instr(16'hE5FF, 3'b000, 0, 0, 0, -1, "b2b_lea");
    run_instr(16'h9FFF, 3'b000, 0, 0, 0, -1, "b2b_not");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int d0, d1;
      d0 = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 4) : $urandom_range(0, 4);
      d1 = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 4) : $urandom_range(0, 4);
      run_instr(16'($urandom), 3'($urandom), $urandom_range(0, 3), d0, d1, -1, "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    run_instr(16'h2000, 3'b000, 0, 10, 0, 4, "ld_abort");
    release_reset("ld_abort");
    run_instr(16'h1042, 3'b000, 0, 0, 0, -1, "add_after_abort");
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldi();
    test_branch();
    test_nop();
    test_timeout_boundary();
    test_store_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lc3_controller.md
LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max cycles waited for complete_data in any memory state (range 1-255).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clock  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  asynchronous active-low reset.
REQ-005 Port: complete_instr  in  1  instruction memory read done.
REQ-006 Port: complete_data  in  1  data memory access done.
REQ-007 Port: Instr_dout  in  16  instruction word from instruction memory.
REQ-008 Port: NZP  in  3  current condition codes {N,Z,P}.
REQ-009 Port: enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC  out  1 each  stage enables.
REQ-010 Port: br_taken  out  1  PC load-target select, qualified by enable_updatePC.
REQ-011 Port: mem_state  out  2  0 = indirect read, 1 = data read, 2 = data write, 3 = idle.
REQ-012 Port: mem_timeout  out  1  sticky memory-timeout error flag.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, DECODE, EXECUTE, MEM_IND, MEM_RD, MEM_WR, WRITEBACK, UPDATE_PC; all outputs SHALL be registered and are Moore functions of the state.
REQ-014 IDLE SHALL go to FETCH on the next edge unconditionally.
REQ-015 FETCH SHALL assert enable_fetch, hold until complete_instr=1, latch Instr_dout into internal ir on that edge and go to DECODE.
REQ-016 DECODE SHALL assert enable_decode for exactly one cycle, then go to EXECUTE.
REQ-017 EXECUTE SHALL assert enable_execute for exactly one cycle; next state SHALL be selected by ir[15:12] per REQ-018..REQ-022.
REQ-018 ADD(0001), AND(0101), NOT(1001), LEA(1110): EXECUTE -> WRITEBACK -> UPDATE_PC.
REQ-019 LD(0010), LDR(0110): EXECUTE -> MEM_RD -> WRITEBACK -> UPDATE_PC; LDI(1010): EXECUTE -> MEM_IND -> MEM_RD -> WRITEBACK -> UPDATE_PC.
REQ-020 ST(0011), STR(0111): EXECUTE -> MEM_WR -> UPDATE_PC; STI(1011): EXECUTE -> MEM_IND -> MEM_WR -> UPDATE_PC.
REQ-021 BR(0000), JMP(1100): EXECUTE -> UPDATE_PC.
REQ-022 All other opcodes SHALL be treated as NOP: EXECUTE -> UPDATE_PC with br_taken=0.
REQ-023 mem_state SHALL be 0/1/2 in MEM_IND/MEM_RD/MEM_WR respectively and 3 in every other state.
REQ-024 Each memory state SHALL hold until complete_data=1 and advance on that edge; a complete_data seen outside memory states SHALL be ignored.
REQ-025 A per-state wait counter SHALL clear on memory-state entry; if it reaches MEM_TIMEOUT without complete_data, the FSM SHALL set mem_timeout=1 and advance as if complete_data had arrived.
REQ-026 complete_data and the timeout firing on the same edge SHALL be treated as a normal completion, with mem_timeout unchanged.
REQ-027 WRITEBACK SHALL assert enable_writeback for one cycle.
REQ-028 UPDATE_PC SHALL assert enable_updatePC for one cycle, then go to FETCH.
REQ-029 br_taken SHALL be computed on the EXECUTE exit edge and driven only during UPDATE_PC, otherwise 0.
REQ-030 br_taken values: BR = |(ir[11:9] & NZP) sampled in EXECUTE; JMP = 1; all other opcodes = 0.
REQ-031 BR with ir[11:9]=000 SHALL give br_taken=0.
REQ-032 At most one enable_* output SHALL be high in any cycle.

Reset
REQ-033 While reset=0, the FSM SHALL be in IDLE with all enables, br_taken and mem_timeout at 0, mem_state=3, ir=16'h0000 and the wait counter at 0.
REQ-034 Reset assertion mid-instruction, including during a memory wait, SHALL abort immediately and asynchronously to the REQ-033 values.
REQ-035 mem_timeout SHALL clear only on reset.

Verification
REQ-036 Reset release, complete_instr=1, Instr_dout=16'h1042 (ADD) -> enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC each high for one cycle in order; br_taken=0.
REQ-037 Instr_dout=16'hA402 (LDI), complete_data after 2 cycles in each memory state -> mem_state 0 for 3 cycles, then 1 for 3 cycles, then WRITEBACK, then UPDATE_PC.
REQ-038 BR 16'h0405 (z=1) with NZP=3'b010 -> br_taken=1 during UPDATE_PC; same instruction with NZP=3'b100 -> br_taken=0.
REQ-039 ST 16'h3203 with complete_data held 0 -> FSM leaves MEM_WR after MEM_TIMEOUT=15 cycles, mem_timeout=1 and stays set through later instructions.
REQ-040 reset=0 asserted during the MEM_RD wait -> all outputs reach reset values without a clock edge; FETCH follows two edges after release.
REQ-041 Opcode 1101 -> EXECUTE then UPDATE_PC with br_taken=0; enable_writeback is never asserted.
